// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared constants for the timer display path.
//   SEG_*   : active-low 7-segment patterns, bit 0 = segment a ... bit 6 = g
//   SEG_OFF : all segments dark
//   AN_OFF  : all anodes disabled (anodes are active-low)
//   IDX_W   : width of the digit index (4 digits)
//   blink_phase_t : lit / dark half of the blink period
// ---------------------------------------------------------------------------
package timer_pkg;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    localparam logic [3:0] AN_OFF   = 4'hF;

    localparam int IDX_W = 2;

    typedef enum logic {
        BLINK_OFF = 1'b0,
        BLINK_ON  = 1'b1
    } blink_phase_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// ---------------------------------------------------------------------------
// bcd_to_7seg
// Combinational BCD to active-low 7-segment decoder. Codes 10..15 are not
// valid BCD and render as a single dash (segment g).
// Ports:
//   i_bcd : 4-bit BCD digit
//   o_seg : active-low segments, o_seg[0]=a ... o_seg[6]=g
// ---------------------------------------------------------------------------
module bcd_to_7seg
    import timer_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner
// Time-multiplexes four BCD timer digits onto a 4-digit common-anode
// 7-segment display as "SS.cc". All four digits are captured together once
// per scan frame so a frame never mixes old and new values. Each digit slot
// starts with a guard window (all anodes off) to avoid ghosting; digit 3 can
// be blanked when it is a leading zero, and the whole display can blink on a
// frame-counted period.
// Ports:
//   clk          : system clock
//   reset_n      : asynchronous reset, active-low
//   ms_ones      : BCD digit 0 (rightmost)
//   ms_tens      : BCD digit 1
//   sec_ones     : BCD digit 2
//   sec_tens     : BCD digit 3 (leftmost)
//   blank_lz     : 1 = blank digit 3 when its captured value is 0
//   blink_en     : 1 = blink the whole display
//   an           : anode enables, active-low, an[i] drives digit i
//   seg          : segments, active-low, seg[0]=a ... seg[6]=g
//   dp           : decimal point, active-low
//   frame_start  : one-cycle pulse after each digit snapshot is captured
// ---------------------------------------------------------------------------
module seven_seg_scanner
    import timer_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 64,
    parameter int BLINK_FRAMES = 125,
    parameter int DP_POS       = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] ms_ones,
    input  logic [3:0] ms_tens,
    input  logic [3:0] sec_ones,
    input  logic [3:0] sec_tens,
    input  logic       blank_lz,
    input  logic       blink_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLK_W = $clog2(BLINK_FRAMES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [15:0]      r_snap;
    blink_phase_t     r_blink_phase;
    logic [BLK_W-1:0] r_blink_cnt;

    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;
    logic             r_frame_start;

    logic             w_slot_end;
    logic             w_load;
    logic [3:0]       w_digit;
    logic [6:0]       w_seg;
    logic             w_lz_blank;
    logic             w_visible;

    assign w_slot_end = (r_cnt == CNT_W'(REFRESH_DIV - 1));
    // The snapshot is taken in the very first cycle of slot 0, which is
    // inside the guard window, so the stale snapshot is never displayed.
    assign w_load     = (r_cnt == '0) && (r_idx == '0);
    assign w_digit    = r_snap[4*r_idx +: 4];
    assign w_lz_blank = (r_idx == IDX_W'(3)) && blank_lz && (r_snap[15:12] == 4'd0);
    assign w_visible  = (r_cnt >= CNT_W'(GUARD_CYCLES)) &&
                        (r_blink_phase == BLINK_ON) && !w_lz_blank;

    bcd_to_7seg u_dec (
        .i_bcd (w_digit),
        .o_seg (w_seg)
    );

    // Slot counter and digit index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= r_idx + IDX_W'(1);
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Per-frame digit snapshot, ordered {digit3, digit2, digit1, digit0}.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_snap <= '0;
        end else if (w_load) begin
            r_snap <= {sec_tens, sec_ones, ms_tens, ms_ones};
        end
    end

    // Blink phase advances on snapshot loads, so toggles are frame-aligned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_phase <= BLINK_ON;
            r_blink_cnt   <= '0;
        end else if (!blink_en) begin
            r_blink_phase <= BLINK_ON;
            r_blink_cnt   <= '0;
        end else if (w_load) begin
            if (r_blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
                r_blink_phase <= (r_blink_phase == BLINK_ON) ? BLINK_OFF : BLINK_ON;
                r_blink_cnt   <= '0;
            end else begin
                r_blink_cnt   <= r_blink_cnt + BLK_W'(1);
            end
        end
    end

    // Output registers: one cycle behind the scan state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_an          <= AN_OFF;
            r_seg         <= SEG_OFF;
            r_dp          <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_load;
            if (w_visible) begin
                r_an  <= ~(4'b0001 << r_idx);
                r_seg <= w_seg;
                r_dp  <= ~(r_idx == IDX_W'(DP_POS));
            end else begin
                r_an  <= AN_OFF;
                r_seg <= SEG_OFF;
                r_dp  <= 1'b1;
            end
        end
    end

    assign an          = r_an;
    assign seg         = r_seg;
    assign dp          = r_dp;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scanner
// Scoreboard bench: the stimulus process pushes the expected lit digits of
// each frame ({an, seg, dp}) when the frame begins; a monitor pops one entry
// each time an anode turns on and also checks per-cycle display rules,
// guard/slot timing and the frame_start period.
// ---------------------------------------------------------------------------
module tb_seven_seg_scanner;

    localparam int REFRESH_DIV  = 8;
    localparam int GUARD_CYCLES = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int DP_POS       = 2;
    localparam int FRAME_CYC    = 4 * REFRESH_DIV;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] ms_ones, ms_tens, sec_ones, sec_tens;
    logic       blank_lz, blink_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;

    int checks = 0;
    int errors = 0;

    logic        mon_en = 1'b0;
    logic [11:0] exp_q[$];

    seven_seg_scanner #(
        .REFRESH_DIV  (REFRESH_DIV),
        .GUARD_CYCLES (GUARD_CYCLES),
        .BLINK_FRAMES (BLINK_FRAMES),
        .DP_POS       (DP_POS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ms_ones     (ms_ones),
        .ms_tens     (ms_tens),
        .sec_ones    (sec_ones),
        .sec_tens    (sec_tens),
        .blank_lz    (blank_lz),
        .blink_en    (blink_en),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // ---------------- monitor ----------------
    logic [3:0]  prev_an  = 4'hF;
    logic [6:0]  prev_seg = 7'h7F;
    int          lit_len  = 0;
    int          dark_len = 0;
    int          cyc      = 0;
    int          last_fs  = -1;
    bit          seen_lit = 0;
    bit          inv_ok;
    logic [11:0] exp_e;

    always @(negedge clk) begin
        cyc++;
        if (!mon_en || !reset_n) begin
            prev_an  = 4'hF;
            prev_seg = 7'h7F;
            lit_len  = 0;
            dark_len = 0;
            seen_lit = 0;
            last_fs  = -1;
        end else begin
            inv_ok = !$isunknown({an, seg, dp, frame_start}) && $onehot0(~an) &&
                     (dp || an == 4'hB) && (an != 4'hF || (seg == 7'h7F && dp));
            if (prev_an != 4'hF && an != 4'hF)
                inv_ok = inv_ok && (an == prev_an) && (seg == prev_seg);
            checks++;
            if (!inv_ok) begin
                errors++;
                $display("FAIL invariant t=%0t an=%h seg=%h dp=%b fs=%b", $time, an, seg, dp, frame_start);
            end

            if (frame_start) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (cyc - last_fs != FRAME_CYC) begin
                        errors++;
                        $display("FAIL fs_period got %0d cycles, want %0d", cyc - last_fs, FRAME_CYC);
                    end
                end
                last_fs = cyc;
            end

            if (an != 4'hF && prev_an == 4'hF) begin
                if (seen_lit) begin
                    checks++;
                    if (dark_len % REFRESH_DIV != GUARD_CYCLES) begin
                        errors++;
                        $display("FAIL guard_len got %0d dark cycles, want %0d mod %0d", dark_len, GUARD_CYCLES, REFRESH_DIV);
                    end
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_digit got an=%h seg=%h dp=%b, want no lit digit", an, seg, dp);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({an, seg, dp} != exp_e) begin
                        errors++;
                        $display("FAIL digit got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                                 an, seg, dp, exp_e[11:8], exp_e[7:1], exp_e[0]);
                    end
                end
                lit_len  = 1;
                seen_lit = 1;
            end else if (an != 4'hF) begin
                lit_len++;
            end else if (prev_an != 4'hF) begin
                checks++;
                if (lit_len != REFRESH_DIV - GUARD_CYCLES) begin
                    errors++;
                    $display("FAIL lit_len got %0d, want %0d", lit_len, REFRESH_DIV - GUARD_CYCLES);
                end
                dark_len = 1;
            end else begin
                dark_len++;
            end
            prev_an  = an;
            prev_seg = seg;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h, want %h", name, got, want);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [6:0] s);
        exp_q.push_back({a, s, (a == 4'hB) ? 1'b0 : 1'b1});
    endtask

    // Expected lit slots of one frame, digit 0 first.
    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3, input bit show3);
        push(4'hE, s0);
        push(4'hD, s1);
        push(4'hB, s2);
        if (show3) push(4'h7, s3);
    endtask

    // Returns at posedge+1 right after frame_start rises.
    task automatic wait_fs();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!frame_start && n < FRAME_CYC + 8);
        checks++;
        if (!frame_start) begin
            errors++;
            $display("FAIL fs_timeout got no frame_start in %0d cycles, want one", n);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_digits got %0d unseen, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n  = 1'b0;
        sec_tens = 4'd1;
        sec_ones = 4'd2;
        ms_tens  = 4'd3;
        ms_ones  = 4'd4;
        blank_lz = 1'b0;
        blink_en = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_an", 16'(an), 16'hF);
        check("reset_seg", 16'(seg), 16'h7F);
        reset_n = 1'b1;
        check("fs_before_first_edge", 16'(frame_start), 16'h0);
        @(posedge clk);
        #1;
        check("fs_after_release", 16'(frame_start), 16'h1);
        repeat (13) @(posedge clk);
        #1;
        check("lit_before_reset", 16'(an), 16'hD);

        // Asynchronous reset in the middle of a lit slot.
        reset_n = 1'b0;
        #1;
        check("async_rst_an", 16'(an), 16'hF);
        check("async_rst_seg", 16'(seg), 16'h7F);
        check("async_rst_dp", 16'(dp), 16'h1);
        check("async_rst_fs", 16'(frame_start), 16'h0);
        repeat (2) @(posedge clk);
        #1;
        mon_en  = 1'b1;
        reset_n = 1'b1;

        // Scan order, then ms_ones changes mid-frame (slot 2).
        wait_fs();
        push_frame(7'h19, 7'h30, 7'h24, 7'h79, 1);
        repeat (18) @(posedge clk);
        #1;
        ms_ones = 4'd7;

        wait_fs();
        push_frame(7'h78, 7'h30, 7'h24, 7'h79, 1);
        ms_tens  = 4'hC;
        sec_tens = 4'd0;

        // Leading-zero blanking on, then off.
        wait_fs();
        blank_lz = 1'b1;
        push_frame(7'h78, 7'h3F, 7'h24, 7'h40, 0);

        wait_fs();
        blank_lz = 1'b0;
        push_frame(7'h78, 7'h3F, 7'h24, 7'h40, 1);
        sec_tens = 4'd1;
        ms_tens  = 4'd3;
        ms_ones  = 4'd4;

        // Blink: enabled after this frame's snapshot.
        wait_fs();
        blink_en = 1'b1;
        push_frame(7'h19, 7'h30, 7'h24, 7'h79, 1);
        wait_fs();
        push_frame(7'h19, 7'h30, 7'h24, 7'h79, 1);
        wait_fs();   // dark
        wait_fs();   // dark
        wait_fs();
        push_frame(7'h19, 7'h30, 7'h24, 7'h79, 1);
        wait_fs();
        push_frame(7'h19, 7'h30, 7'h24, 7'h79, 1);
        // This frame starts dark; dropping blink_en relights it from slot 0.
        wait_fs();
        blink_en = 1'b0;
        push_frame(7'h19, 7'h30, 7'h24, 7'h79, 1);
        wait_fs();
        push_frame(7'h19, 7'h30, 7'h24, 7'h79, 1);

        wait_fs();
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
